lvds_sync_decoder: RTL and testbench

- Downstream of the LVDS receive channel: consumes its aligned parallel word stream (tdata) once bitslip alignment reports done.
- Decodes embedded sensor sync words (frame start/end, line start/end) and emits a pixel stream with start-of-frame and end-of-line markers.
- Also reports measured line/frame geometry and a sync error pulse to the control logic.
- Runs in the parallel (clkdiv) domain. One word is consumed per clock while enabled; there is no backpressure.

---
 rtl/lvds_sync_decoder_if.sv | 21 ++
 rtl/lvds_sync_decoder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lvds_sync_decoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lvds_sync_decoder_if.sv
// ---------------------------------------------------------------------------
// lvds_sync_decoder_if
// Pixel output stream of the LVDS sync decoder. There is no backpressure, so
// the stream carries data and sideband markers only.
//   tdata  : pixel word
//   tvalid : one cycle per pixel
//   tuser  : first pixel of a frame
//   tlast  : last pixel of a line
// Modports: master drives the stream (decoder), slave observes it.
// ---------------------------------------------------------------------------
interface lvds_sync_decoder_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast);
  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast);
endinterface

// File: rtl/lvds_sync_decoder.sv
// ---------------------------------------------------------------------------
// lvds_sync_decoder
// Decodes embedded sensor sync words (FS/FE/LS/LE) from the aligned parallel
// word stream of the LVDS receive channel. It emits a pixel stream with
// start-of-frame (tuser) and end-of-line (tlast) markers, and reports the
// measured line and frame geometry plus a one-cycle sync error pulse.
// Ports:
//   clk         : parallel-domain clock (clkdiv of the receive channel)
//   reset       : asynchronous active-low reset
//   in_en       : stream enable (bitslip_done)
//   in_data     : aligned word, sampled every edge while in_en = 1
//   m_if        : pixel stream (master modport)
//   line_pixels : pixel count of the last completed line
//   frame_lines : line count of the last completed frame
//   in_frame    : high between FS and FE
//   sync_err    : one-cycle sync error pulse
//   err_count   : saturating sync error count (only with LVDS_SYNC_ERR_CNT_EN)
// Optional feature macro: LVDS_SYNC_ERR_CNT_EN
// ---------------------------------------------------------------------------
module lvds_sync_decoder #(
  parameter int                    DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0] FS_CODE       = 10'h2AA,
  parameter logic [DATA_WIDTH-1:0] FE_CODE       = 10'h3AA,
  parameter logic [DATA_WIDTH-1:0] LS_CODE       = 10'h0AA,
  parameter logic [DATA_WIDTH-1:0] LE_CODE       = 10'h1AA,
  parameter int                    ACTIVE_PIXELS = 640,
  parameter int                    ACTIVE_LINES  = 480,
  parameter int                    CNT_WIDTH     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  lvds_sync_decoder_if.master   m_if,
  output logic [CNT_WIDTH-1:0]  line_pixels,
  output logic [CNT_WIDTH-1:0]  frame_lines,
  output logic                  in_frame,
  output logic                  sync_err
`ifdef LVDS_SYNC_ERR_CNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  typedef enum logic [1:0] {
    WAIT_ALIGN = 2'd0,
    WAIT_FS    = 2'd1,
    WAIT_LS    = 2'd2,
    IN_LINE    = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] ACT_PX = CNT_WIDTH'(ACTIVE_PIXELS);
  localparam logic [CNT_WIDTH-1:0] ACT_LN = CNT_WIDTH'(ACTIVE_LINES);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_WIDTH'(1);
    end
  endfunction

  state_e                state_q, state_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  sof_pending_q, sof_pending_d;
  logic [CNT_WIDTH-1:0]  px_cnt_q, px_cnt_d;
  logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic [CNT_WIDTH-1:0]  line_pixels_q, line_pixels_d;
  logic [CNT_WIDTH-1:0]  frame_lines_q, frame_lines_d;
  logic                  in_frame_q, in_frame_d;
  logic                  sync_err_q, sync_err_d;
  logic                  frame_ctl_s;

  logic is_fs_s, is_fe_s, is_ls_s, is_le_s;
  assign is_fs_s = (in_data == FS_CODE);
  assign is_fe_s = (in_data == FE_CODE);
  assign is_ls_s = (in_data == LS_CODE);
  assign is_le_s = (in_data == LE_CODE);

  // Next-state and output decode for the sync state machine.
  always_comb begin
    state_d       = state_q;
    hold_vld_d    = hold_vld_q;
    hold_data_d   = hold_data_q;
    sof_pending_d = sof_pending_q;
    px_cnt_d      = px_cnt_q;
    line_cnt_d    = line_cnt_q;
    tdata_d       = tdata_q;
    tvalid_d      = 1'b0;
    tuser_d       = 1'b0;
    tlast_d       = 1'b0;
    line_pixels_d = line_pixels_q;
    frame_lines_d = frame_lines_q;
    in_frame_d    = in_frame_q;
    sync_err_d    = 1'b0;
    // frame_ctl_s selects the between-lines handling of LS/FE/FS, shared by
    // WAIT_LS and by FS/FE arriving in the middle of a line.
    frame_ctl_s   = 1'b0;

    if (!in_en) begin
      // Alignment lost: drop everything silently and re-acquire.
      state_d       = WAIT_ALIGN;
      hold_vld_d    = 1'b0;
      in_frame_d    = 1'b0;
      sof_pending_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_ALIGN: begin
          state_d = WAIT_FS;
        end
        WAIT_FS: begin
          if (is_fs_s) begin
            state_d       = WAIT_LS;
            in_frame_d    = 1'b1;
            sof_pending_d = 1'b1;
            line_cnt_d    = {CNT_WIDTH{1'b0}};
          end else begin
            state_d = WAIT_FS;
          end
        end
        WAIT_LS: begin
          frame_ctl_s = 1'b1;
        end
        IN_LINE: begin
          if (is_le_s) begin
            if (hold_vld_q) begin
              tvalid_d      = 1'b1;
              tdata_d       = hold_data_q;
              tuser_d       = sof_pending_q;
              tlast_d       = 1'b1;
              sof_pending_d = 1'b0;
            end else begin
              tvalid_d = 1'b0;
            end
            hold_vld_d    = 1'b0;
            line_pixels_d = px_cnt_q;
            line_cnt_d    = sat_inc(line_cnt_q);
            sync_err_d    = (px_cnt_q != ACT_PX);
            state_d       = WAIT_LS;
          end else if (is_ls_s || is_fs_s || is_fe_s) begin
            // Unexpected sync inside a line: the held pixel is discarded.
            sync_err_d = 1'b1;
            hold_vld_d = 1'b0;
            if (is_ls_s) begin
              px_cnt_d = {CNT_WIDTH{1'b0}};
              state_d  = IN_LINE;
            end else begin
              frame_ctl_s = 1'b1;
            end
          end else begin
            // Pixel: the previous one leaves only once a successor proves it
            // was not the last pixel of the line.
            if (hold_vld_q) begin
              tvalid_d      = 1'b1;
              tdata_d       = hold_data_q;
              tuser_d       = sof_pending_q;
              sof_pending_d = 1'b0;
            end else begin
              tvalid_d = 1'b0;
            end
            hold_data_d = in_data;
            hold_vld_d  = 1'b1;
            px_cnt_d    = sat_inc(px_cnt_q);
          end
        end
        default: begin
          state_d = WAIT_ALIGN;
        end
      endcase

      if (frame_ctl_s) begin
        if (is_ls_s) begin
          state_d  = IN_LINE;
          px_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (is_fe_s) begin
          state_d       = WAIT_FS;
          frame_lines_d = line_cnt_q;
          in_frame_d    = 1'b0;
          if (line_cnt_q != ACT_LN) begin
            sync_err_d = 1'b1;
          end else begin
            sync_err_d = sync_err_d;
          end
        end else if (is_fs_s) begin
          state_d       = WAIT_LS;
          sync_err_d    = 1'b1;
          line_cnt_d    = {CNT_WIDTH{1'b0}};
          sof_pending_d = 1'b1;
        end else begin
          state_d = state_d;
        end
      end else begin
        frame_ctl_s = 1'b0;
      end
    end
  end

  // State, hold register, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= WAIT_ALIGN;
      hold_vld_q    <= 1'b0;
      hold_data_q   <= {DATA_WIDTH{1'b0}};
      sof_pending_q <= 1'b0;
      px_cnt_q      <= {CNT_WIDTH{1'b0}};
      line_cnt_q    <= {CNT_WIDTH{1'b0}};
      tdata_q       <= {DATA_WIDTH{1'b0}};
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      line_pixels_q <= {CNT_WIDTH{1'b0}};
      frame_lines_q <= {CNT_WIDTH{1'b0}};
      in_frame_q    <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_vld_q    <= hold_vld_d;
      hold_data_q   <= hold_data_d;
      sof_pending_q <= sof_pending_d;
      px_cnt_q      <= px_cnt_d;
      line_cnt_q    <= line_cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      line_pixels_q <= line_pixels_d;
      frame_lines_q <= frame_lines_d;
      in_frame_q    <= in_frame_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign m_if.tdata  = tdata_q;
  assign m_if.tvalid = tvalid_q;
  assign m_if.tuser  = tuser_q;
  assign m_if.tlast  = tlast_q;
  assign line_pixels = line_pixels_q;
  assign frame_lines = frame_lines_q;
  assign in_frame    = in_frame_q;
  assign sync_err    = sync_err_q;

`ifdef LVDS_SYNC_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Saturating count of sync error pulses, cleared only by reset.
  always_comb begin
    if (sync_err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= 16'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_lvds_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_lvds_sync_decoder
// Directed bench for lvds_sync_decoder with ACTIVE_PIXELS = 4 and
// ACTIVE_LINES = 2. Each word is applied, one clock edge taken, and the
// registered outputs compared with hand-computed values 1 ns later.
// ---------------------------------------------------------------------------
module tb_lvds_sync_decoder;
  localparam int DW = 10;
  localparam int CW = 12;
  localparam logic [DW-1:0] FS = 10'h2AA;
  localparam logic [DW-1:0] FE = 10'h3AA;
  localparam logic [DW-1:0] LS = 10'h0AA;
  localparam logic [DW-1:0] LE = 10'h1AA;
  localparam logic [DW-1:0] BL = 10'h010;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_en = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] line_pixels, frame_lines;
  logic          in_frame, sync_err;
`ifdef LVDS_SYNC_ERR_CNT_EN
  logic [15:0]   err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lvds_sync_decoder_if #(.DATA_WIDTH(DW)) m_if ();

  lvds_sync_decoder #(
    .DATA_WIDTH(DW), .ACTIVE_PIXELS(4), .ACTIVE_LINES(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .in_data(in_data),
    .m_if(m_if),
    .line_pixels(line_pixels), .frame_lines(frame_lines),
    .in_frame(in_frame), .sync_err(sync_err)
`ifdef LVDS_SYNC_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [DW-1:0] w);
    in_en   = en;
    in_data = w;
    @(posedge clk);
    #1;
  endtask

  // Apply one word and check the pixel stream and error pulse it produces.
  task automatic sx(input string tag, input logic en, input logic [DW-1:0] w,
                    input logic v, input logic [DW-1:0] d, input logic u,
                    input logic l, input logic e);
    step(en, w);
    check_eq({tag, ".tvalid"}, 32'(m_if.tvalid), 32'(v));
    check_eq({tag, ".tuser"}, 32'(m_if.tuser), 32'(u));
    check_eq({tag, ".tlast"}, 32'(m_if.tlast), 32'(l));
    check_eq({tag, ".sync_err"}, 32'(sync_err), 32'(e));
    if (v) begin
      check_eq({tag, ".tdata"}, 32'(m_if.tdata), 32'(d));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("rst.tuser", 32'(m_if.tuser), 32'd0);
    check_eq("rst.tlast", 32'(m_if.tlast), 32'd0);
    check_eq("rst.tdata", 32'(m_if.tdata), 32'd0);
    check_eq("rst.line_pixels", 32'(line_pixels), 32'd0);
    check_eq("rst.frame_lines", 32'(frame_lines), 32'd0);
    check_eq("rst.in_frame", 32'(in_frame), 32'd0);
    check_eq("rst.sync_err", 32'(sync_err), 32'd0);
    reset = 1'b1;

    // Complete frame presented while in_en = 0 must be ignored.
    sx("dis", 1'b0, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("dis", 1'b0, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) sx("dis", 1'b0, DW'(i), 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("dis", 1'b0, LE, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("dis", 1'b0, FE, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("dis", 1'b0, BL, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("dis", 1'b0, BL, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    check_eq("dis.in_frame", 32'(in_frame), 32'd0);

    // Nominal frame: 2 lines of 4 pixels
    sx("nom.align", 1'b1, BL, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("nom.fs", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    check_eq("nom.in_frame", 32'(in_frame), 32'd1);
    for (int i = 0; i < 3; i++) sx("nom.blank", 1'b1, BL, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("nom.ls0", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("nom.p1", 1'b1, 10'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("nom.p2", 1'b1, 10'd2, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
    sx("nom.p3", 1'b1, 10'd3, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0);
    sx("nom.p4", 1'b1, 10'd4, 1'b1, 10'd3, 1'b0, 1'b0, 1'b0);
    sx("nom.le0", 1'b1, LE, 1'b1, 10'd4, 1'b0, 1'b1, 1'b0);
    check_eq("nom.line_pixels", 32'(line_pixels), 32'd4);
    sx("nom.ls1", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("nom.p5", 1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("nom.p6", 1'b1, 10'd6, 1'b1, 10'd5, 1'b0, 1'b0, 1'b0);
    sx("nom.p7", 1'b1, 10'd7, 1'b1, 10'd6, 1'b0, 1'b0, 1'b0);
    sx("nom.p8", 1'b1, 10'd8, 1'b1, 10'd7, 1'b0, 1'b0, 1'b0);
    sx("nom.le1", 1'b1, LE, 1'b1, 10'd8, 1'b0, 1'b1, 1'b0);
    sx("nom.fe", 1'b1, FE, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    check_eq("nom.frame_lines", 32'(frame_lines), 32'd2);
    check_eq("nom.line_pixels2", 32'(line_pixels), 32'd4);
    check_eq("nom.in_frame_end", 32'(in_frame), 32'd0);

    // Short line, then a sync code inside a line
    sx("sh.fs", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("sh.ls", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("sh.p1", 1'b1, 10'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("sh.p2", 1'b1, 10'd2, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
    sx("sh.p3", 1'b1, 10'd3, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0);
    sx("sh.le", 1'b1, LE, 1'b1, 10'd3, 1'b0, 1'b1, 1'b1);
    check_eq("sh.line_pixels", 32'(line_pixels), 32'd3);
    sx("cil.ls", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("cil.p1", 1'b1, 10'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("cil.p2", 1'b1, 10'd2, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0);
    sx("cil.ls2", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    sx("cil.p3", 1'b1, 10'd3, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("cil.p4", 1'b1, 10'd4, 1'b1, 10'd3, 1'b0, 1'b0, 1'b0);
    sx("cil.p5", 1'b1, 10'd5, 1'b1, 10'd4, 1'b0, 1'b0, 1'b0);
    sx("cil.p6", 1'b1, 10'd6, 1'b1, 10'd5, 1'b0, 1'b0, 1'b0);
    sx("cil.le", 1'b1, LE, 1'b1, 10'd6, 1'b0, 1'b1, 1'b0);
    check_eq("cil.line_pixels", 32'(line_pixels), 32'd4);
    sx("cil.fe", 1'b1, FE, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    check_eq("cil.frame_lines", 32'(frame_lines), 32'd2);

    // in_en drop mid-line: held pixel 2 must vanish
    sx("en.fs", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.ls", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.p1", 1'b1, 10'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.p2", 1'b1, 10'd2, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sx("en.off", 1'b0, 10'd3, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    check_eq("en.in_frame", 32'(in_frame), 32'd0);
    sx("en.g0", 1'b1, 10'h155, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.g1", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.g2", 1'b1, 10'h033, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.g3", 1'b1, LE, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.fs2", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.ls2", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.p9", 1'b1, 10'd9, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("en.le", 1'b1, LE, 1'b1, 10'd9, 1'b1, 1'b1, 1'b1);
    check_eq("en.line_pixels", 32'(line_pixels), 32'd1);
`ifdef LVDS_SYNC_ERR_CNT_EN
    check_eq("ecnt.three", 32'(err_count), 32'd3);
`endif

    // Pixel counter saturation on an overlong line, then FE inside a line
    sx("sat.ls", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4100; i++) step(1'b1, 10'h011);
    sx("sat.le", 1'b1, LE, 1'b1, 10'h011, 1'b0, 1'b1, 1'b1);
    check_eq("sat.line_pixels", 32'(line_pixels), 32'hFFF);
    sx("fil.ls", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("fil.p7", 1'b1, 10'd7, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("fil.fe", 1'b1, FE, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    check_eq("fil.frame_lines", 32'(frame_lines), 32'd2);
    check_eq("fil.in_frame", 32'(in_frame), 32'd0);

    // Asynchronous reset while a pixel is on the output
    sx("ar.fs", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.ls", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.p1", 1'b1, 10'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.p2", 1'b1, 10'd2, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar.tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("ar.tuser", 32'(m_if.tuser), 32'd0);
    check_eq("ar.tdata", 32'(m_if.tdata), 32'd0);
    check_eq("ar.line_pixels", 32'(line_pixels), 32'd0);
    check_eq("ar.frame_lines", 32'(frame_lines), 32'd0);
    check_eq("ar.in_frame", 32'(in_frame), 32'd0);
`ifdef LVDS_SYNC_ERR_CNT_EN
    check_eq("ecnt.reset", 32'(err_count), 32'd0);
`endif
    #2;
    reset = 1'b1;
    // First enabled word only re-aligns, so this FS/LS pair is not decoded.
    sx("ar.w0", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.w1", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.w2", 1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.w3", 1'b1, 10'd6, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    check_eq("ar.in_frame2", 32'(in_frame), 32'd0);
    sx("ar.fs2", 1'b1, FS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.ls2", 1'b1, LS, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.p5", 1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    sx("ar.p6", 1'b1, 10'd6, 1'b1, 10'd5, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
